// File: rtl/fp_accum_driver.sv
// Frame accumulator that sums a stream of single-precision floats through an external
// two-operand adder using a load / result_ready / result_ack handshake.
// Optional watchdog on the adder wait: define ACC_TIMEOUT_EN.
module fp_accum_driver #(
  parameter int WIDTH          = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             add_load,
  output logic [WIDTH-1:0] add_num1,
  output logic [WIDTH-1:0] add_num2,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_result_ready,
  output logic             add_result_ack,
  output logic [WIDTH-1:0] sum_data,
  output logic             sum_valid,
  input  logic             sum_ack,
  output logic [CNT_W-1:0] sum_count,
  output logic             busy,
  output logic             timeout_err
);

  // state | meaning
  // IDLE  | waiting for first element of a frame
  // GETX  | waiting for next element
  // LOAD  | one-cycle request pulse to adder
  // WAIT  | waiting for adder result
  // ACK   | one-cycle acknowledge pulse to adder
  // DONE  | frame sum held until consumer acknowledges
  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_GETX = 6'b000010,
    S_LOAD = 6'b000100,
    S_WAIT = 6'b001000,
    S_ACK  = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, x_q, num1_q;
  logic [CNT_W-1:0] count_q;
  logic             last_q;
  logic             accept;
  logic             wd_expire;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = in_last ? S_DONE : S_GETX;
      S_GETX: if (accept) state_d = S_LOAD;
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (add_result_ready) state_d = S_ACK;
        else if (wd_expire)   state_d = S_IDLE;
      end
      S_ACK:  state_d = last_q ? S_DONE : S_GETX;
      S_DONE: if (sum_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state_q == S_IDLE) || (state_q == S_GETX);
    add_load       = (state_q == S_LOAD);
    add_result_ack = (state_q == S_ACK);
    sum_valid      = (state_q == S_DONE);
    busy           = (state_q != S_IDLE);
    sum_data       = (state_q == S_DONE) ? acc_q : '0;
    add_num1       = num1_q;
    add_num2       = x_q;
    sum_count      = count_q;
  end

  // acc is overwritten by the adder result in WAIT, so operand 1 gets its own copy
  // to stay stable until the acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      x_q     <= '0;
      num1_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (state_q == S_IDLE && accept) begin
        acc_q   <= in_data;
        count_q <= CNT_W'(1);
      end
      if (state_q == S_GETX && accept) begin
        x_q    <= in_data;
        num1_q <= acc_q;
        last_q <= in_last;
        if (count_q != '1) count_q <= count_q + CNT_W'(1);
      end
      if (state_q == S_WAIT && add_result_ready) acc_q <= add_result;
    end
  end

`ifdef ACC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;
  logic          timeout_q;

  assign wd_expire   = (state_q == S_WAIT) && !add_result_ready && (wd_q == '0);
  assign timeout_err = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_LOAD) wd_q <= TW'(TIMEOUT_CYCLES - 1);
      else if (state_q == S_WAIT && wd_q != '0) wd_q <= wd_q - TW'(1);
      if (wd_expire) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accum_driver.sv
// Directed bench for fp_accum_driver: behavioural adder slave with adjustable latency
// and a scoreboard of expected frame sums and counts.
module tb_fp_accum_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        add_load, add_result_ready, add_result_ack;
  logic [31:0] add_num1, add_num2, add_result;
  logic [31:0] sum_data;
  logic        sum_valid, sum_ack, busy, timeout_err;
  logic [15:0] sum_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_data_q[$];
  int          exp_cnt_q[$];
  logic [31:0] fr[8];
  int  lat      = 2;
  int  load_cnt = 0;
  int  ack_cnt  = 0;
  bit  s_busy   = 1'b0;
  bit  s_block  = 1'b0;

  fp_accum_driver dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_load(add_load), .add_num1(add_num1), .add_num2(add_num2),
    .add_result(add_result), .add_result_ready(add_result_ready),
    .add_result_ack(add_result_ack),
    .sum_data(sum_data), .sum_valid(sum_valid), .sum_ack(sum_ack),
    .sum_count(sum_count), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    m = m * (2.0 ** e);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real a;
    int  e;
    int  mant;
    logic s;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mant = $rtoi((a - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(mant)};
  endfunction

  // adder slave: captures operands on load, answers after lat cycles, holds until ack
  initial begin
    logic [31:0] c1, c2;
    int  cnt;
    bit  pl, pa;
    add_result_ready = 1'b0;
    add_result = 32'd0;
    pl = 1'b0; pa = 1'b0; cnt = 0; c1 = 0; c2 = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        s_busy = 1'b0; add_result_ready = 1'b0; add_result = 32'd0; pl = 1'b0; pa = 1'b0;
      end else begin
        if (add_load) check("load_pulse_width", 32'(pl), 32'd0);
        if (add_result_ack) begin
          check("ack_pulse_width", 32'(pa), 32'd0);
          ack_cnt++;
        end
        if (s_busy) begin
          check("num1_stable", add_num1, c1);
          check("num2_stable", add_num2, c2);
          check("load_while_open", 32'(add_load), 32'd0);
          if (add_result_ready && add_result_ack) begin
            add_result_ready = 1'b0;
            s_busy = 1'b0;
          end else if (!add_result_ready && !s_block) begin
            if (cnt == 0) begin
              add_result_ready = 1'b1;
              add_result = r2f(f2r(c1) + f2r(c2));
            end else cnt--;
          end
        end else if (add_load) begin
          c1 = add_num1; c2 = add_num2;
          s_busy = 1'b1;
          cnt = lat - 1;
          load_cnt++;
        end
        pl = add_load;
        pa = add_result_ack;
      end
    end
  end

  task automatic push_elem(input logic [31:0] d, input logic last);
    int b = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && b < 200) begin @(negedge clk); b++; end
    if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int n);
    real s = 0.0;
    for (int i = 0; i < n; i++) s = s + f2r(fr[i]);
    exp_data_q.push_back(r2f(s));
    exp_cnt_q.push_back(n);
    for (int i = 0; i < n; i++) push_elem(fr[i], i == n - 1);
  endtask

  task automatic wait_sum(input int hold);
    int b = 0;
    logic [31:0] ed;
    int ec;
    while (!sum_valid && b < 500) begin @(negedge clk); b++; end
    check("sum_valid_seen", 32'(sum_valid), 32'd1);
    if (sum_valid && exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      ec = exp_cnt_q.pop_front();
      check("sum_data", sum_data, ed);
      check("sum_count", 32'(sum_count), 32'(ec));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(sum_valid), 32'd1);
        check("hold_data", sum_data, ed);
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      sum_ack = 1'b1;
      @(negedge clk);
      sum_ack = 1'b0;
      check("valid_cleared", 32'(sum_valid), 32'd0);
      check("back_to_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int b;
    reset = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; sum_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_add_load", 32'(add_load), 32'd0);
    check("rst_ack", 32'(add_result_ack), 32'd0);
    check("rst_sum_count", 32'(sum_count), 32'd0);
    check("rst_sum_data", sum_data, 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1.0 + 2.0 + 3.0, consumer holds off for 5 cycles
    lat = 2; load_cnt = 0; ack_cnt = 0;
    fr[0] = 32'h3F800000; fr[1] = 32'h40000000; fr[2] = 32'h40400000;
    send_frame(3);
    wait_sum(5);
    check("t1_loads", 32'(load_cnt), 32'd2);
    check("t1_acks", 32'(ack_cnt), 32'd2);

    // single element passes through with no adder traffic
    load_cnt = 0;
    fr[0] = 32'h3F800000;
    send_frame(1);
    wait_sum(0);
    check("t2_loads", 32'(load_cnt), 32'd0);

    // stray sum_ack in IDLE has no effect
    sum_ack = 1'b1;
    @(negedge clk);
    sum_ack = 1'b0;
    check("stray_ack_idle", 32'(busy), 32'd0);
    check("stray_ack_valid", 32'(sum_valid), 32'd0);

    // slow slave: 0.5 + 0.25 + 4.0 - 1.0
    lat = 7; load_cnt = 0;
    fr[0] = 32'h3F000000; fr[1] = 32'h3E800000; fr[2] = 32'h40800000; fr[3] = 32'hBF800000;
    send_frame(4);
    wait_sum(1);
    check("t4_loads", 32'(load_cnt), 32'd3);

    // fast slave: 10.0 + 2.5
    lat = 1;
    fr[0] = 32'h41200000; fr[1] = 32'h40200000;
    send_frame(2);
    wait_sum(0);

    // reset while waiting on the adder
    lat = 30;
    fr[0] = 32'h3F800000; fr[1] = 32'h3F800000;
    send_frame(2);
    b = 0;
    while (!s_busy && b < 50) begin @(negedge clk); b++; end
    repeat (3) @(negedge clk);
    check("t5_busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_add_load", 32'(add_load), 32'd0);
    check("t5_rst_num1", add_num1, 32'd0);
    check("t5_rst_count", 32'(sum_count), 32'd0);
    void'(exp_data_q.pop_back());
    void'(exp_cnt_q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    lat = 2;
    send_frame(2);
    wait_sum(0);

`ifdef ACC_TIMEOUT_EN
    // slave never answers: watchdog aborts the frame
    s_block = 1'b1;
    fr[0] = 32'h3F800000; fr[1] = 32'h40000000;
    send_frame(2);
    void'(exp_data_q.pop_back());
    void'(exp_cnt_q.pop_back());
    b = 0;
    while (busy && b < 200) begin
      @(negedge clk);
      check("to_no_sum_valid", 32'(sum_valid), 32'd0);
      b++;
    end
    check("to_idle", 32'(busy), 32'd0);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_in_ready", 32'(in_ready), 32'd1);
`else
    check("no_timeout_err", 32'(timeout_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
